// File: rtl/avalon_master_arbiter.sv
// Round-robin arbiter that shares one avalon_mm_master command port between N_REQ requesters.
// Optional watchdog abort of hung transactions is enabled by defining AVALON_ARB_TIMEOUT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no owner; pick the next requester in round-robin order
// ST_BUSY    | owner's command latched on m_*; wait for m_done (or timeout)
// ST_RELEASE | one dead cycle after completion before the next arbitration
module avalon_master_arbiter #(
  parameter int          N_REQ          = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ABORT_DATA     = 32'hDEADBEEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_rnw,
  input  logic [32*N_REQ-1:0]   req_address,
  input  logic [32*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]      req_grant,
  output logic [N_REQ-1:0]      req_done,
  output logic [N_REQ-1:0]      req_err,
  output logic [31:0]           req_rdata,
  output logic                  m_start,
  output logic                  m_rnw,
  output logic [31:0]           m_address,
  output logic [31:0]           m_wdata,
  input  logic                  m_done,
  input  logic [31:0]           m_rdata,
  output logic                  busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [N_REQ-1:0] win_onehot;
  logic             win_rnw;
  logic [31:0]      win_address;
  logic [31:0]      win_wdata;

`ifdef AVALON_ARB_TIMEOUT_EN
  logic [31:0]      wd_cnt;
`endif

  // Search starts one past the last owner so a re-asserted request loses to other pending ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_onehot  = '0;
    win_rnw     = 1'b0;
    win_address = '0;
    win_wdata   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_onehot[i] = win_found;
        win_rnw       = req_rnw[i];
        win_address   = req_address[32*i +: 32];
        win_wdata     = req_wdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      req_grant  <= '0;
      req_done   <= '0;
      req_rdata  <= '0;
      m_start    <= 1'b0;
      m_rnw      <= 1'b0;
      m_address  <= '0;
      m_wdata    <= '0;
      busy       <= 1'b0;
`ifdef AVALON_ARB_TIMEOUT_EN
      req_err    <= '0;
      wd_cnt     <= '0;
`endif
    end else begin
      req_done <= '0;
`ifdef AVALON_ARB_TIMEOUT_EN
      req_err  <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            req_grant <= win_onehot;
            last_grant <= last_grant;
            m_rnw     <= win_rnw;
            m_address <= win_address;
            m_wdata   <= win_wdata;
            m_start   <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_BUSY;
`ifdef AVALON_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        ST_BUSY: begin
          // req_grant is the owner's one-hot, so it doubles as the completion mask.
          if (m_done) begin
            if (m_rnw) req_rdata <= m_rdata;
            req_done   <= req_grant;
            req_grant  <= '0;
            m_start    <= 1'b0;
            last_grant <= win_idx_of(req_grant);
            state      <= ST_RELEASE;
          end
`ifdef AVALON_ARB_TIMEOUT_EN
          else if (wd_cnt + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
            req_rdata  <= ABORT_DATA;
            req_done   <= req_grant;
            req_err    <= req_grant;
            req_grant  <= '0;
            m_start    <= 1'b0;
            last_grant <= win_idx_of(req_grant);
            state      <= ST_RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        ST_RELEASE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef AVALON_ARB_TIMEOUT_EN
  assign req_err = '0;
`endif

  function automatic logic [IDX_W-1:0] win_idx_of(input logic [N_REQ-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endmodule

// File: doc/avalon_master_arbiter.md
# avalon_master_arbiter

Round-robin arbiter that shares the single `avalon_mm_master` command port (start/rnw/address/data/done) between `N_REQ` internal requesters, such as the UART bridge and the debug/loader path. Each requester gets exclusive use of the master for one complete transaction. The arbiter then rotates priority. An optional watchdog aborts transactions whose `done` never arrives.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles of `m_start` high without `m_done`. Only used with the macro defined.
- `ABORT_DATA`, 32'hDEADBEEF: value returned on `req_rdata` for an aborted transaction.

Ports:
- `CLK` input 1: clock, rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `req` input N_REQ: per-requester transaction request. Level; held high until that requester's `req_done`.
- `req_rnw` input N_REQ: 1 = read, 0 = write.
- `req_address` input 32*N_REQ: flattened; requester i uses bits [32i+31:32i].
- `req_wdata` input 32*N_REQ: flattened write data, same packing.
- `req_grant` output N_REQ: one-hot; bit set while that requester owns the master.
- `req_done` output N_REQ: one-cycle completion pulse to the owner.
- `req_err` output N_REQ: one-cycle pulse coincident with `req_done` on watchdog abort.
- `req_rdata` output 32: read data of the last completed transaction, shared by all requesters.
- `m_start` output 1: to master `start`. Level, high for the whole transaction.
- `m_rnw` output 1: to master `rnw`.
- `m_address` output 32: to master `address_to_access`.
- `m_wdata` output 32: to master `data_to_write`.
- `m_done` input 1: from master `done`.
- `m_rdata` input 32: from master `data_read`.
- `busy` output 1: high in BUSY and RELEASE.

## Operation
- FSM states: IDLE, BUSY, RELEASE.
- **IDLE, no `req` bit set**: stay in IDLE.
- **IDLE, any `req` bit set**:
  - Winner is the first set bit searching from `(last_grant+1) mod N_REQ` upward with wrap.
  - Register `grant_idx`, `req_grant` one-hot, and `m_rnw`/`m_address`/`m_wdata` from the winner's inputs.
  - Set `m_start` = 1 and go to BUSY.
- **BUSY**:
  - Hold `m_*` constant. Requester inputs are not re-sampled; command changes are ignored.
  - On `m_done` = 1: capture `m_rdata` into `req_rdata` (reads only; writes leave it unchanged), pulse `req_done[grant_idx]`, set `m_start` = 0, `last_grant` <= `grant_idx`, go to RELEASE.
- **RELEASE**:
  - One cycle. `req_grant` cleared, `m_start` = 0. Go to IDLE.
- **Requester withdraws `req` during BUSY**: the transaction still completes and `req_done` still pulses.
- **`req` still high in IDLE after a `req_done`**: treated as a new request, but it loses to any other pending requester because of rotation.
- **Several `req` bits rise in the same cycle**: the round-robin order decides. Nothing is dropped; losers wait.
- **`N_REQ` = 1**: behaves as a pass-through sequencer with a 2-cycle turnaround.

## Timing
- **Reset values**: state IDLE, `last_grant` = N_REQ-1 (so requester 0 wins first). `req_grant`, `req_done`, `req_err`, `m_start`, `m_rnw`, `busy` = 0. `req_rdata`, `m_address`, `m_wdata` = 0. Watchdog counter = 0.
- **Grant latency**: `req` sampled high at edge k gives `m_start`, `req_grant`, and `busy` high after edge k.
- **Completion latency**: `m_done` sampled at edge j gives `req_done`/`req_rdata` valid and `m_start` low after edge j.
- **Turnaround**: minimum 2 cycles with `m_start` low between transactions (RELEASE + IDLE).
- **`RST` mid-transaction**: all outputs return to reset values at the next edge. A pending `req_done` is not generated. The master must also be reset by the same `RST`.
- **`m_done` outside BUSY**: ignored.

## Configuration
- **Macro `AVALON_ARB_TIMEOUT_EN` defined**:
  - A 32-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES` with `m_done` still low, exit BUSY exactly as on `m_done`.
  - Pulse `req_done` and `req_err` for the owner, load `req_rdata` = `ABORT_DATA`, and go to RELEASE.
  - If `m_done` and the timeout coincide, `m_done` wins with no error.
- **Macro undefined**: no counter. `req_err` tied to 0. BUSY waits indefinitely for `m_done`.

## Test plan
- **Single requester**: after reset, requester 0 issues a read of 0x0000000C; master returns `m_done` 3 cycles later with `m_rdata` 0x000000A5 -> `m_start` high exactly 4 cycles, `req_done[0]` pulses once, `req_rdata` = 0x000000A5, `req_err` = 0.
- **Simultaneous requests**: `req` = 2'b11 held continuously, writes 0x11 to 0x0 (req0) and 0x22 to 0x4 (req1) -> grants alternate 0,1,0,1. `m_address`/`m_wdata` match the owner every transaction. Gap of 2 idle cycles between `m_start` pulses.
- **Requester withdrawal**: requester 1 drops `req` 1 cycle into BUSY -> transaction completes, `req_done[1]` pulses, no second grant to 1.
- **Reset mid-transaction**: assert `RST` in the 2nd BUSY cycle -> next cycle all outputs 0, state IDLE. The following request is granted to requester 0.
- **Watchdog abort** (`AVALON_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16, `m_done` held low): `req_done` and `req_err` pulse together after 16 BUSY cycles, `req_rdata` = 0xDEADBEEF, `m_start` low. The next request proceeds normally.
- **Timeout coincidence** (`AVALON_ARB_TIMEOUT_EN`): `m_done` asserted in the same cycle the counter hits 16 -> `req_err` = 0, `req_rdata` = `m_rdata`.
